i2s_frame_controller: RTL and testbench
=======================================

Name: i2s_frame_controller

Overview:
- Master-mode I2S frame sequencer, running entirely on mclk.
- Generates sclk and lrclk from mclk.
- Serializes one stereo sample per frame to the DAC (sdout) and deserializes one stereo sample per frame from the ADC (sdin).
- Bridges the guitar-pedal effect datapath (valid/ready TX, valid-pulse RX) and the codec pins; it replaces free-running clock division with frame-aligned sequencing.

Parameters:
- SCLK_HALF, 4, mclk cycles per sclk half-period (sclk = mclk/(2*SCLK_HALF)); must be >= 2.
- BITS_PER_CH, 32, sclk periods per channel slot; must be > DATA_W.
- DATA_W, 24, sample width (two's complement).

Ports:
- mclk  in  1  master clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request; sampled each cycle.
- tx_left  in  DATA_W  left sample to transmit.
- tx_right  in  DATA_W  right sample to transmit.
- tx_valid  in  1  TX sample offered.
- tx_ready  out  1  TX holding register empty.
- rx_left  out  DATA_W  last received left sample.
- rx_right  out  DATA_W  last received right sample.
- rx_valid  out  1  one-cycle pulse: rx_left/rx_right updated.
- sdin  in  1  ADC serial data.
- sclk  out  1  bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdout  out  1  DAC serial data.
- underrun  out  1  sticky: a frame started with no TX sample.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset (async): state IDLE; sclk=0, lrclk=0, sdout=0, rx_valid=0, rx_left=rx_right=0, underrun=0; holding register empty (tx_ready=1); all counters 0.
- Holding register:
  - tx_valid && tx_ready writes {tx_left, tx_right} and sets full.
  - tx_ready = !full, registered-state based, independent of tx_valid.
  - Accepted in IDLE or RUN.
- Frame-start event (FS): empty-to-shift transfer.
  - If full: shift regs <= holding content at start of cycle; full cleared.
  - If empty: shift regs <= 0; underrun set.
  - A handshake in the same cycle as FS writes holding for the next frame; it never feeds the current frame.
- State machine:
  - IDLE: sclk, lrclk, sdout held 0; counters held 0.
  - IDLE -> RUN when en=1; FS occurs in that transition cycle.
  - RUN -> RUN at each frame boundary if en=1 (FS + rx_valid).
  - RUN -> IDLE at a frame boundary if en=0 (rx_valid pulses, no FS, no underrun).
  - en is only evaluated at frame boundaries; deassert mid-frame completes the frame.
- Timing in RUN, cycle t relative to RUN entry:
  - slot s = t / (2*SCLK_HALF), range 0..2*BITS_PER_CH-1.
  - sclk = 0 in the first half of each slot, 1 in the second half.
  - lrclk = (s >= BITS_PER_CH); changes only with sclk falling.
  - Frame boundary at t = 2*SCLK_HALF*2*BITS_PER_CH (512 mclk cycles with defaults), then repeats.
- sdout, constant for a whole slot:
  - Channel bit k = s mod BITS_PER_CH.
  - k=0 outputs 0 (I2S one-bit delay).
  - k=1..DATA_W outputs data[DATA_W-k], MSB first.
  - k > DATA_W outputs 0.
  - Left slots send the left word; right slots send the right word.
- sdin: sampled on each sclk rising edge (cycle where sclk 0->1) for k=1..DATA_W into the matching channel shift register, MSB first; other bits are ignored.
- RX output: at each frame boundary, rx_left/rx_right <= assembled words and rx_valid=1 for exactly one cycle; values hold until the next boundary.
- underrun: set has priority over clr_underrun in the same cycle.
- Reset mid-frame: immediate return to the reset values above; partial RX is discarded; no rx_valid.

Test Plan:
- Reset, preload L=0x123456 R=0xABCDEF, en=1, sdin looped to sdout -> lrclk low for 256 cycles, high for 256; sdout at left slot 1 = 0 and slot 2 = 0; rx_valid at cycle 512 with rx_left=0x123456, rx_right=0xABCDEF; underrun=0.
- en=1 with empty holding -> sdout all 0 for frame 1; underrun=1 from cycle 1; clr_underrun pulse clears it; a pulse coinciding with the next FS underrun leaves it set.
- Continuous stream, with tx_valid presented in the FS cycle while holding is empty -> that sample is sent in the following frame; the current frame sends 0 and sets underrun.
- Deassert en at slot 10 -> frame completes; rx_valid at the boundary; then sclk=lrclk=sdout=0 and tx_ready stays 0 if holding was full.
- Assert rst at slot 40 -> all outputs 0 immediately (async); no rx_valid; restart yields correct frame from cycle 0.
- SCLK_HALF=2, BITS_PER_CH=25, DATA_W=24, sample 0x800001 -> frame = 200 cycles; k=24 carries LSB=1; rx matches.

Source files
------------

// File: rtl/i2s_frame_controller.sv
// i2s_frame_controller: master-mode I2S frame sequencer with TX holding register and RX capture
module i2s_frame_controller #(
  parameter int SCLK_HALF   = 4,
  parameter int BITS_PER_CH = 32,
  parameter int DATA_W      = 24
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  input  logic              sdin,
  output logic              sclk,
  output logic              lrclk,
  output logic              sdout,
  output logic              underrun,
  input  logic              clr_underrun
);
  localparam int PW = $clog2(2 * SCLK_HALF);
  localparam int SW = $clog2(2 * BITS_PER_CH);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(SCLK_HALF);
  localparam logic [SW-1:0] SL_LAST = SW'(2 * BITS_PER_CH - 1);
  localparam logic [SW-1:0] SL_HALF = SW'(BITS_PER_CH);
  localparam logic [SW-1:0] K_MAX   = SW'(DATA_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state, w_next;
  logic [PW-1:0]     r_ph;
  logic [SW-1:0]     r_slot;
  logic              r_full, r_underrun, r_rx_valid;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_sh_l, r_sh_r, r_rs_l, r_rs_r, r_rx_l, r_rx_r;
  logic              w_run, w_bnd, w_fs, w_acc, w_lr, w_kv, w_slot_end;
  logic [SW-1:0]     w_k;

  assign w_run      = r_state == RUN;
  assign w_slot_end = r_ph == PH_LAST;
  assign w_bnd      = w_run && w_slot_end && r_slot == SL_LAST;
  assign w_acc      = tx_valid && !r_full;
  assign w_lr       = r_slot >= SL_HALF;
  assign w_k        = w_lr ? r_slot - SL_HALF : r_slot;
  assign w_kv       = w_k != '0 && w_k <= K_MAX;

  assign tx_ready = !r_full;
  assign underrun = r_underrun;
  assign rx_valid = r_rx_valid;
  assign rx_left  = r_rx_l;
  assign rx_right = r_rx_r;
  assign sclk     = w_run && r_ph >= PH_RISE;
  assign lrclk    = w_run && w_lr;
  assign sdout    = w_run && w_kv && (w_lr ? r_sh_r[DATA_W-1] : r_sh_l[DATA_W-1]);

  // Next state and frame-start: en only matters in IDLE or on a frame boundary
  always_comb begin
    w_fs   = en && (!w_run || w_bnd);
    w_next = w_run ? ((w_bnd && !en) ? IDLE : RUN) : (en ? RUN : IDLE);
  end

  // State register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Phase within a slot and slot within a frame; both restart on every frame start and in IDLE
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_ph   <= '0;
      r_slot <= '0;
    end else if (!w_run || w_bnd) begin
      r_ph   <= '0;
      r_slot <= '0;
    end else begin
      r_ph <= w_slot_end ? '0 : r_ph + PW'(1);
      if (w_slot_end) r_slot <= r_slot + SW'(1);
    end
  end

  // Holding register and sticky underrun; a same-cycle handshake only fills holding for the next frame
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_full     <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_full     <= w_acc || (r_full && !w_fs);
      r_underrun <= (w_fs && !r_full) || (r_underrun && !clr_underrun);
      if (w_acc) begin
        r_hold_l <= tx_left;
        r_hold_r <= tx_right;
      end
    end
  end

  // TX shift registers: loaded at frame start, advanced at the end of each data slot so the MSB drives sdout
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (w_fs) begin
      r_sh_l <= r_full ? r_hold_l : '0;
      r_sh_r <= r_full ? r_hold_r : '0;
    end else if (w_run && w_slot_end && w_kv) begin
      if (w_lr) r_sh_r <= r_sh_r << 1;
      else      r_sh_l <= r_sh_l << 1;
    end
  end

  // RX capture on the sclk rising cycle of data slots; words published with a one-cycle pulse at the boundary
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_rs_l     <= '0;
      r_rs_r     <= '0;
      r_rx_l     <= '0;
      r_rx_r     <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_bnd;
      if (w_bnd) begin
        r_rx_l <= r_rs_l;
        r_rx_r <= r_rs_r;
      end
      if (w_run && r_ph == PH_RISE && w_kv) begin
        if (w_lr) r_rs_r <= {r_rs_r[DATA_W-2:0], sdin};
        else      r_rs_l <= {r_rs_l[DATA_W-2:0], sdin};
      end
    end
  end
endmodule

// File: tb/tb_i2s_frame_controller.sv
// tb_i2s_frame_controller: randomized scoreboard bench with a frame-level reference model
module tb_i2s_frame_controller;
  localparam int SH = 4, BPC = 32, DW = 24, FR = 2 * SH * 2 * BPC;
  localparam int SH2 = 2, BPC2 = 25, FR2 = 2 * SH2 * 2 * BPC2;

  logic mclk = 0, rst = 0, en = 0, tx_valid = 0, clr = 0, lb = 1, rnd_sdin = 0;
  logic [DW-1:0] txl = '0, txr = '0, rx_left, rx_right;
  logic tx_ready, rx_valid, sdin, sclk, lrclk, sdout, underrun;

  logic b_rst = 0, b_en = 0, b_tx_valid = 0;
  logic [DW-1:0] b_txl = '0, b_txr = '0, b_rx_left, b_rx_right;
  logic b_tx_ready, b_rx_valid, b_sdin, b_sclk, b_lrclk, b_sdout, b_underrun;

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  bit m_run = 0, m_full = 0, m_uf = 0, m_rxv = 0;
  int m_t = 0;
  logic [DW-1:0] m_hold[2], m_cur[2], m_rx[2];
  logic [2*DW-1:0] exp_q[$];

  always #5 mclk = ~mclk;
  assign sdin   = lb ? sdout : rnd_sdin;
  assign b_sdin = b_sdout;

  i2s_frame_controller dut (
    .mclk(mclk), .rst(rst), .en(en), .tx_left(txl), .tx_right(txr), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .sdin(sdin), .sclk(sclk), .lrclk(lrclk), .sdout(sdout), .underrun(underrun),
    .clr_underrun(clr)
  );

  i2s_frame_controller #(.SCLK_HALF(SH2), .BITS_PER_CH(BPC2), .DATA_W(DW)) dut2 (
    .mclk(mclk), .rst(b_rst), .en(b_en), .tx_left(b_txl), .tx_right(b_txr), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .rx_left(b_rx_left), .rx_right(b_rx_right), .rx_valid(b_rx_valid),
    .sdin(b_sdin), .sclk(b_sclk), .lrclk(b_lrclk), .sdout(b_sdout), .underrun(b_underrun),
    .clr_underrun(1'b0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_sd();
    int s, k;
    logic [DW-1:0] w;
    if (!m_run) return 1'b0;
    s = m_t / (2 * SH);
    k = s % BPC;
    w = (s >= BPC) ? m_cur[1] : m_cur[0];
    return (k >= 1 && k <= DW) ? w[DW-k] : 1'b0;
  endfunction

  // Reference model: frame position as a plain cycle count, words as whole values
  initial forever begin
    @(posedge mclk or posedge rst);
    if (rst) begin
      m_run = 0; m_t = 0; m_full = 0; m_uf = 0; m_rxv = 0;
      m_rx[0] = '0; m_rx[1] = '0; m_cur[0] = '0; m_cur[1] = '0;
      exp_q.delete();
    end else begin
      automatic bit bit_in = lb ? exp_sd() : rnd_sdin;
      automatic bit old_full = m_full;
      automatic bit acc = tx_valid && !old_full;
      automatic bit bnd = m_run && m_t == FR - 1;
      automatic bit fs = en && (!m_run || bnd);
      if (m_run && (m_t % (2 * SH)) == SH) begin
        automatic int s = m_t / (2 * SH);
        automatic int k = s % BPC;
        if (k >= 1 && k <= DW) m_rx[s >= BPC][DW-k] = bit_in;
      end
      m_rxv = bnd;
      if (bnd) exp_q.push_back({m_rx[0], m_rx[1]});
      if (fs) begin
        m_cur[0] = old_full ? m_hold[0] : '0;
        m_cur[1] = old_full ? m_hold[1] : '0;
      end
      m_uf = (fs && !old_full) || (m_uf && !clr);
      if (acc) begin
        m_hold[0] = txl;
        m_hold[1] = txr;
      end
      m_full = acc || (old_full && !fs);
      m_t = (!m_run || bnd) ? 0 : m_t + 1;
      m_run = m_run ? !(bnd && !en) : en;
    end
  end

  // Pin monitor: clocks, data line and status flags against the model every cycle
  initial forever begin
    @(negedge mclk);
    if (chk_on) begin
      automatic logic [5:0] e = {m_run && (m_t % (2 * SH)) >= SH, m_run && (m_t / (2 * SH)) >= BPC,
                                 exp_sd(), !m_full, m_uf, m_rxv};
      n_chk++;
      if ({sclk, lrclk, sdout, tx_ready, underrun, rx_valid} !== e) begin
        n_err++;
        $display("FAIL pins t=%0d act=%b exp=%b", m_t, {sclk, lrclk, sdout, tx_ready, underrun, rx_valid}, e);
      end
    end
  end

  // Scoreboard monitor: each rx_valid pulse pops one expected stereo word
  initial forever begin
    @(negedge mclk);
    if (chk_on && rx_valid === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected act=%0h exp=none", {rx_left, rx_right});
      end else begin
        automatic logic [2*DW-1:0] e = exp_q.pop_front();
        if ({rx_left, rx_right} !== e) begin
          n_err++;
          $display("FAIL rx_word act=%0h exp=%0h", {rx_left, rx_right}, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #2;
    end
  endtask

  task automatic wait_t(input int t);
    for (int i = 0; i < 3 * FR; i++) begin
      if (m_run && m_t == t) return;
      step(1);
    end
    chk("wait_t_timeout", 64'(t), 64'(t + 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * FR && m_run; i++) step(1);
  endtask

  task automatic push_tx(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit took = 0;
    tx_valid = 1; txl = l; txr = r;
    for (int i = 0; i < 3 * FR && !took; i++) begin
      took = tx_ready;
      step(1);
    end
    tx_valid = 0;
    if (!took) chk("push_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int rxv_at;
    logic [DW-1:0] r2;
    #1 rst = 1; b_rst = 1; chk_on = 1;
    step(3);
    chk("reset_state", {rx_left, rx_right, rx_valid, underrun, tx_ready, sclk, lrclk, sdout}, {48'h0, 6'b001000});
    rst = 0; b_rst = 0;
    step(1);
    push_tx(24'h123456, 24'hABCDEF);
    en = 1;
    step(1);
    wait_t(FR - 1);
    tx_valid = 1; txl = DW'($urandom); txr = DW'($urandom);
    step(1);
    tx_valid = 0;
    chk("fs_handshake_underrun", {underrun, tx_ready}, 2'b10);
    wait_t(100);
    clr = 1;
    step(1);
    clr = 0;
    chk("clr_underrun", underrun, 0);
    wait_t(FR - 1);
    step(1);
    wait_t(FR - 1);
    clr = 1;
    step(1);
    clr = 0;
    chk("underrun_set_priority", underrun, 1);
    lb = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      tx_valid = $urandom_range(0, 3) == 0;
      txl = DW'($urandom); txr = DW'($urandom);
      rnd_sdin = $urandom_range(0, 1) == 1;
      clr = $urandom_range(0, 199) == 0;
      step(1);
    end
    tx_valid = 0; clr = 0; lb = 1;
    wait_t(FR - 1);
    step(1);
    push_tx(DW'($urandom), DW'($urandom));
    wait_t(10 * 2 * SH);
    en = 0;
    wait_idle();
    step(5);
    chk("idle_after_stop", {sclk, lrclk, sdout, tx_ready}, 4'b0000);
    en = 1;
    step(1);
    wait_t(40 * 2 * SH);
    rst = 1;
    #1;
    chk("async_reset", {rx_left, rx_right, rx_valid, underrun, tx_ready, sclk, lrclk, sdout}, {48'h0, 6'b001000});
    en = 0;
    step(2);
    rst = 0;
    step(1);
    push_tx(DW'($urandom), DW'($urandom));
    en = 1;
    step(1);
    wait_t(FR - 1);
    step(1);
    en = 0;
    wait_idle();
    step(4);
    chk("queue_drained", 64'(exp_q.size()), 0);

    r2 = DW'($urandom);
    b_tx_valid = 1; b_txl = 24'h800001; b_txr = r2;
    step(1);
    b_tx_valid = 0;
    b_en = 1;
    step(1);
    rxv_at = -1;
    for (int t = 0; t < 2 * FR2 && rxv_at < 0; t++) begin
      if (t == 1 * 2 * SH2 + 1) chk("b_left_msb", b_sdout, 1);
      if (t == 23 * 2 * SH2 + 1) chk("b_left_bit1", b_sdout, 0);
      if (t == 24 * 2 * SH2 + 1) chk("b_left_lsb", b_sdout, 1);
      if (t == (BPC2 + 24) * 2 * SH2 + 1) chk("b_right_lsb", b_sdout, r2[0]);
      if (t == 50) b_en = 0;
      if (b_rx_valid) rxv_at = t;
      step(1);
    end
    chk("b_frame_len", 64'(rxv_at), 64'(FR2));
    chk("b_rx_word", {b_rx_left, b_rx_right}, {24'h800001, r2});
    step(3);
    chk("b_idle", {b_sclk, b_lrclk, b_sdout, b_rx_valid}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
